// File: rtl/blk_seq_ctrl.sv
// Block-sequence controller: follows each active pixel through a frame tiled in
// HBLKS x VBLKS blocks, flags block/row boundaries, frame end and bad geometry.
module blk_seq_ctrl #(
  parameter int HBLKS = 10,
  parameter int VBLKS = 10,
  parameter int HPXS  = 30,
  parameter int VPXS  = 30
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     vs_i,
  input  logic                     de_i,
  output logic [$clog2(HBLKS)-1:0] ht_o,
  output logic [$clog2(VBLKS)-1:0] vt_o,
  output logic                     de_o,
  output logic                     h_save_o,
  output logic                     v_save_o,
  output logic                     frame_done_o,
  output logic                     err_o
);
  localparam int HTW = $clog2(HBLKS);
  localparam int VTW = $clog2(VBLKS);
  localparam int HPW = (HPXS > 1) ? $clog2(HPXS) : 1;
  localparam int VPW = (VPXS > 1) ? $clog2(VPXS) : 1;
  localparam logic [HTW-1:0] HT_MAX  = HTW'(HBLKS - 1);
  localparam logic [VTW-1:0] VT_MAX  = VTW'(VBLKS - 1);
  localparam logic [HPW-1:0] HPX_MAX = HPW'(HPXS - 1);
  localparam logic [VPW-1:0] VPX_MAX = VPW'(VPXS - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, SKIP} state_t;

  state_t         state_q, state_d;
  logic           vs_q, de_q, full_q;
  logic [HPW-1:0] hpx;
  logic [HTW-1:0] ht;
  logic [VPW-1:0] vpx;
  logic [VTW-1:0] vt;
  logic           vs_rise, line_end;
  logic           pix_ok, pix_drop, eol;
  logic           h_save_d, v_save_d, done_d, err_d;

  assign vs_rise  = vs_i & ~vs_q;
  assign line_end = de_q & ~de_i;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (vs_rise)     state_d = en_i ? ACTIVE : SKIP;
    else if (done_d) state_d = IDLE;
  end

  // vs_i edge wins over pixel and line-end events in the same cycle
  always_comb begin
    pix_ok   = 1'b0;
    pix_drop = 1'b0;
    eol      = 1'b0;
    if (state_q == ACTIVE && !vs_rise) begin
      pix_ok   = de_i & ~full_q;
      pix_drop = de_i & full_q;
      eol      = line_end;
    end
    h_save_d = pix_ok && (hpx == HPX_MAX);
    v_save_d = eol && (vpx == VPX_MAX);
    done_d   = v_save_d && (vt == VT_MAX);
    err_d    = pix_drop || (eol && !full_q);
  end

  // full_q marks a line that has already delivered HBLKS*HPXS pixels
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q <= 1'b0; de_q <= 1'b0; full_q <= 1'b0;
      hpx  <= '0;   ht   <= '0;   vpx    <= '0;   vt <= '0;
    end else begin
      vs_q <= vs_i;
      de_q <= vs_rise ? 1'b0 : de_i;
      if (vs_rise) begin
        full_q <= 1'b0;
        hpx <= '0; ht <= '0; vpx <= '0; vt <= '0;
      end else if (pix_ok) begin
        if (hpx == HPX_MAX) begin
          hpx <= '0;
          if (ht == HT_MAX) full_q <= 1'b1;
          else              ht     <= ht + HTW'(1);
        end else begin
          hpx <= hpx + HPW'(1);
        end
      end else if (eol) begin
        full_q <= 1'b0;
        hpx    <= '0;
        ht     <= '0;
        if (vpx == VPX_MAX) begin
          vpx <= '0;
          vt  <= (vt == VT_MAX) ? '0 : vt + VTW'(1);
        end else begin
          vpx <= vpx + VPW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ht_o <= '0; vt_o <= '0;
      de_o <= 1'b0; h_save_o <= 1'b0; v_save_o <= 1'b0;
      frame_done_o <= 1'b0; err_o <= 1'b0;
    end else begin
      ht_o         <= ht;
      vt_o         <= vt;
      de_o         <= pix_ok;
      h_save_o     <= h_save_d;
      v_save_o     <= v_save_d;
      frame_done_o <= done_d;
      err_o        <= err_o | err_d;
    end
  end
endmodule

// File: tb/tb_blk_seq_ctrl.sv
// Scoreboard bench for blk_seq_ctrl: an index-based frame model pushes one
// expected output word per driven cycle; a monitor pops and compares.
module tb_blk_seq_ctrl;
  localparam int HB = 2, VB = 2, HP = 3, VP = 2;
  localparam int M_IDLE = 0, M_ACT = 1, M_SKIP = 2;

  logic clk_i = 1'b0, rst_i = 1'b1, en_i = 1'b0, vs_i = 1'b0, de_i = 1'b0;
  logic [$clog2(HB)-1:0] ht_o;
  logic [$clog2(VB)-1:0] vt_o;
  logic de_o, h_save_o, v_save_o, frame_done_o, err_o;

  int    n_chk = 0, n_err = 0;
  string stage = "reset";

  typedef struct {logic de, hs, vs, fd, err; int ht, vt;} exp_t;
  exp_t exp_q[$];

  int   m_st = M_IDLE, m_pix = 0, m_line = 0;
  logic m_pde = 1'b0, m_pvs = 1'b0, m_err = 1'b0;

  blk_seq_ctrl #(.HBLKS(HB), .VBLKS(VB), .HPXS(HP), .VPXS(VP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .vs_i(vs_i), .de_i(de_i),
    .ht_o(ht_o), .vt_o(vt_o), .de_o(de_o), .h_save_o(h_save_o),
    .v_save_o(v_save_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pk(input logic de, hs, vs, fd, err, input int ht, vt);
    return {de, hs, vs, fd, err, 3'b000, 4'(ht), 4'(vt)};
  endfunction

  // One input cycle: drive at negedge and push what the outputs must show after the next posedge
  task automatic cyc(input logic vs, input logic de);
    exp_t e;
    logic rise;
    @(negedge clk_i);
    vs_i = vs;
    de_i = de;
    rise = vs && !m_pvs;
    e = '{default: 0};
    if (rise) begin
      m_st   = en_i ? M_ACT : M_SKIP;
      m_pix  = 0;
      m_line = 0;
    end else if (m_st == M_ACT) begin
      if (de) begin
        if (m_pix < HB * HP) begin
          e.de = 1'b1;
          e.hs = (m_pix % HP) == HP - 1;
          e.ht = m_pix / HP;
          e.vt = m_line / VP;
        end else begin
          m_err = 1'b1;
        end
        m_pix++;
      end else if (m_pde) begin
        if (m_pix < HB * HP) m_err = 1'b1;
        e.vs = (m_line % VP) == VP - 1;
        if (m_line == VB * VP - 1) begin
          e.fd = 1'b1;
          m_st = M_IDLE;
        end
        m_line++;
        m_pix = 0;
      end
    end
    m_pde = rise ? 1'b0 : de;
    m_pvs = vs;
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic vsync(input logic en);
    en_i = en;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  // Reset lands between clock edges; outputs must clear before any edge
  task automatic rst_pulse();
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk({stage, ":async_rst"},
        pk(de_o, h_save_o, v_save_o, frame_done_o, err_o, int'(ht_o), int'(vt_o)), 16'h0);
    de_i = 1'b0;
    vs_i = 1'b0;
    m_st = M_IDLE; m_pix = 0; m_line = 0;
    m_pde = 1'b0; m_pvs = 1'b0; m_err = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(stage,
            pk(de_o, h_save_o, v_save_o, frame_done_o, err_o,
               e.de ? int'(ht_o) : 0, e.de ? int'(vt_o) : 0),
            pk(e.de, e.hs, e.vs, e.fd, e.err, e.ht, e.vt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    chk("reset", pk(de_o, h_save_o, v_save_o, frame_done_o, err_o, int'(ht_o), int'(vt_o)), 16'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    stage = "full";
    vsync(1'b1);
    repeat (4) line(6);
    line(6);                      // after frame_done: must be ignored

    stage = "short";
    vsync(1'b1);
    line(5);
    repeat (3) line(6);

    stage = "rst_mid";
    vsync(1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    rst_pulse();

    stage = "long";
    vsync(1'b1);
    line(8);
    repeat (3) line(6);
    rst_pulse();

    stage = "skip";
    vsync(1'b0);
    repeat (4) line(6);

    stage = "abort";
    vsync(1'b1);
    line(6);
    line(6);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);              // vs edge on the 3rd pixel of line 3
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (4) line(6);

    repeat (2) @(posedge clk_i);
    #2;
    chk("sb_drain", 16'(exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
